// File: rtl/sram_fb_arbiter.sv
// sram_fb_arbiter
// Shares the framebuffer SRAM between display prefetch reads, ADC plot writes
// and a built-in clear engine. Fixed priority read > clear > plot write, with
// a bounded read run so plot writes cannot starve. A direction change between
// read and write costs one bubble cycle so the SRAM bus can turn around.
//
// Ports
//   clk, reset                   : clock, synchronous active-high reset
//   rd_req/rd_addr/rd_ready      : display read request channel
//   rd_data_valid/rd_data        : read data return to the display
//   wr_req/wr_addr/wr_data       : plot write request channel
//   wr_ready                     : plot write accepted this cycle
//   clr_start/clr_busy/clr_done  : clear engine control and status
//   mem_valid/mem_ready/mem_we   : transaction handshake to SRAM controller
//   mem_addr/mem_wdata           : transaction address and write data
//   mem_rvalid/mem_rdata         : in-order read return from SRAM controller
module sram_fb_arbiter #(
    parameter int                   ADDR_BITS   = 20,
    parameter int                   DATA_BITS   = 16,
    parameter int                   FB_WORDS    = 307200,
    parameter logic [DATA_BITS-1:0] CLEAR_VALUE = '0,
    parameter int                   MAX_RD_RUN  = 8
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 rd_req,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_ready,
    output logic                 rd_data_valid,
    output logic [DATA_BITS-1:0] rd_data,

    input  logic                 wr_req,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_ready,

    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic                 clr_done,

    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic                 mem_rvalid,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    localparam int                   RUN_W    = $clog2(MAX_RD_RUN + 1);
    localparam logic [RUN_W-1:0]     RUN_MAX  = RUN_W'(MAX_RD_RUN);
    localparam logic [ADDR_BITS-1:0] CLR_LAST = ADDR_BITS'(FB_WORDS - 1);

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RD   = 2'd1,
        SEL_CLR  = 2'd2,
        SEL_WR   = 2'd3
    } sel_t;

    // Control state
    logic                 dir_q;
    logic                 pend_q;
    sel_t                 sel_q;
    logic [RUN_W-1:0]     rd_run;
    logic [ADDR_BITS-1:0] clr_addr;

    // Held bus values for cycles with no transfer offered
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;

    sel_t pick;
    logic pick_dir;
    logic bubble;
    logic starve;
    logic xfer;
    logic clr_acc;
    logic clr_last;

    // Read return needs no tagging: the display is the only reader and the
    // controller returns data in order.
    assign rd_data_valid = mem_rvalid;
    assign rd_data       = mem_rdata;

    // ---- Arbitration (zero latency, frozen while a transfer is stalled) ----
    always_comb begin
        starve = wr_req && (rd_run == RUN_MAX);

        // A stalled transfer keeps its selection; requesters hold their
        // inputs until ready, and clr_addr only moves on acceptance, so the
        // bus stays stable without re-arbitrating.
        if (pend_q)        pick = sel_q;
        else if (starve)   pick = SEL_WR;
        else if (rd_req)   pick = SEL_RD;
        else if (clr_busy) pick = SEL_CLR;
        else if (wr_req)   pick = SEL_WR;
        else               pick = SEL_NONE;

        pick_dir = (pick == SEL_RD) ? DIR_RD : DIR_WR;
        bubble   = (pick != SEL_NONE) && (pick_dir != dir_q);

        // Outputs are gated during reset so nothing can transfer in the cycle
        // reset is sampled.
        mem_valid = !reset && (pick != SEL_NONE) && !bubble;
        xfer      = mem_valid && mem_ready;
        rd_ready  = xfer && (pick == SEL_RD);
        wr_ready  = xfer && (pick == SEL_WR);
        clr_acc   = xfer && (pick == SEL_CLR);
        clr_last  = (clr_addr == CLR_LAST);

        mem_we    = mem_valid ? pick_dir : dir_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_valid) begin
            case (pick)
                SEL_RD:  mem_addr = rd_addr;
                SEL_CLR: begin
                    mem_addr  = clr_addr;
                    mem_wdata = CLEAR_VALUE;
                end
                SEL_WR:  begin
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end
                default: ;
            endcase
        end
    end

    // ---- Bus hold registers (data path, not reset) ----
    always_ff @(posedge clk) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
    end

    // ---- Control state: direction, stall freeze, read run, clear engine ----
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q    <= DIR_RD;
            pend_q   <= 1'b0;
            sel_q    <= SEL_NONE;
            rd_run   <= '0;
            clr_busy <= 1'b0;
            clr_addr <= '0;
            clr_done <= 1'b0;
        end else begin
            pend_q <= mem_valid && !mem_ready;
            sel_q  <= pick;

            // The bubble cycle itself turns the bus around; arbitration
            // re-runs on the next cycle with the new direction.
            if (bubble) begin
                dir_q <= pick_dir;
            end

            // Run length only matters while a plot write is waiting. It
            // saturates because a full run forces the write next anyway.
            if (!wr_req || wr_ready || clr_acc) begin
                rd_run <= '0;
            end else if (rd_ready && (rd_run != RUN_MAX)) begin
                rd_run <= rd_run + RUN_W'(1);
            end

            clr_done <= clr_acc && clr_last;

            // clr_start is only honoured while idle; on the final acceptance
            // the engine is still busy, so a coincident start is dropped.
            if (clr_acc) begin
                if (clr_last) begin
                    clr_busy <= 1'b0;
                    clr_addr <= '0;
                end else begin
                    clr_addr <= clr_addr + ADDR_BITS'(1);
                end
            end else if (clr_start && !clr_busy) begin
                clr_busy <= 1'b1;
                clr_addr <= '0;
            end
        end
    end

endmodule

// File: doc/sram_fb_arbiter.md
# sram_fb_arbiter

Shares the single framebuffer SRAM between three requesters in the ADC XY scope path: display prefetch reads, ADC plot writes, and a built-in framebuffer clear engine. It sits between the requesters and the SRAM transaction controller, all in the `clk` domain. It enforces a fixed priority with anti-starvation for plot writes, and it inserts bus-turnaround bubbles whenever the access direction changes.

## Interface
- `ADDR_BITS`, 20, SRAM word address width
- `DATA_BITS`, 16, SRAM word width
- `FB_WORDS`, 307200, words cleared per clear pass, starting at address 0
- `CLEAR_VALUE`, 0, word written by the clear engine
- `MAX_RD_RUN`, 8, maximum consecutive read grants while a plot write waits
- `clk` input 1: system clock; only clock
- `reset` input 1: synchronous, active-high
- `rd_req` input 1: display read request
- `rd_addr` input ADDR_BITS: read address
- `rd_ready` output 1: read accepted this cycle
- `rd_data_valid` output 1: read data strobe
- `rd_data` output DATA_BITS: read data
- `wr_req` input 1: plot write request
- `wr_addr` input ADDR_BITS: write address
- `wr_data` input DATA_BITS: write data
- `wr_ready` output 1: write accepted this cycle
- `clr_start` input 1: one-cycle pulse that starts a clear pass
- `clr_busy` output 1: clear pass in progress
- `clr_done` output 1: one-cycle pulse after the last clear write is accepted
- `mem_valid` output 1: transaction valid to the SRAM controller
- `mem_ready` input 1: SRAM controller accepts the transaction
- `mem_we` output 1: 1 = write, 0 = read
- `mem_addr` output ADDR_BITS: transaction address
- `mem_wdata` output DATA_BITS: write data
- `mem_rvalid` input 1: read data return strobe (in order)
- `mem_rdata` input DATA_BITS: returned read data

## Operation
**Handshake**
- A requester holds its req, addr and data stable until it sees ready.
- A transfer occurs when `mem_valid && mem_ready`.
- `rd_ready` and `wr_ready` are combinational. Each is asserted only in its own transfer cycle.

**Priority**
- Default order: read > clear > plot write.
- Anti-starvation: `rd_run` counts consecutive accepted reads while `wr_req` is high.
  - When `rd_run == MAX_RD_RUN` and `wr_req` is high, the plot write is selected ahead of the read and the clear.
  - `rd_run` clears on any accepted write, or whenever `wr_req` is low.

**Direction register**
- `dir_q` holds the direction of the last transfer: 0 = read, 1 = write. It resets to read.
- If the selected op's direction differs from `dir_q`, the block does the following in that cycle:
  - drives `mem_valid=0` (the bubble);
  - sets `dir_q` to the new direction.
- Arbitration re-runs next cycle. Requests can change during the bubble, which may cost a second bubble. That is acceptable.

**Clear engine**
- `clr_start` while idle sets `clr_busy=1` and `clr_addr=0`.
- Each accepted clear write increments `clr_addr`.
- Acceptance at `clr_addr == FB_WORDS-1` does two things: it clears `clr_busy`, and it pulses `clr_done` on the next cycle.
- `clr_start` while busy is ignored and does not restart the pass.
- `clr_start` in the same cycle as the final clear acceptance is also ignored.

**Read return**
- `rd_data_valid` = `mem_rvalid` and `rd_data` = `mem_rdata`, passed straight through.
- The display is the only reader, so no tagging is needed.

**Mux**
- When the selection is a clear, the block drives `mem_we=1`, `mem_addr=clr_addr` and `mem_wdata=CLEAR_VALUE`.
- When nothing is selected, `mem_addr` and `mem_wdata` hold their last values; the arbiter registers them.

## Timing
- Arbitration is zero latency. A request presented in cycle N, with direction equal to `dir_q` and top priority, gives `mem_valid=1` in cycle N.
- A direction change costs exactly 1 bubble cycle.
- A back-to-back same-direction stream sustains 1 transfer per cycle when `mem_ready=1`.
- While `mem_ready=0`, the selection is frozen: no re-arbitration until the transfer completes, so `mem_addr`, `mem_we` and `mem_wdata` stay stable.
- Reset (any cycle, including mid-clear) forces all outputs and state to their reset values:
  - outputs `mem_valid=0`, `rd_ready=0`, `wr_ready=0`, `clr_busy=0`, `clr_done=0`;
  - state `clr_addr=0`, `rd_run=0`, `dir_q=read`.
- After reset, a clear pass must be restarted with `clr_start`.
- Clear width rule: `clr_addr` is ADDR_BITS wide. `FB_WORDS` ≤ 2^ADDR_BITS, and the address never wraps.

## Test plan
- **Continuous reads:** `rd_req` held high, `mem_ready=1`, 10 reads. Expect 10 consecutive `rd_ready` pulses, no bubbles, `mem_we=0` throughout.
- **Read-then-write turnaround:** a read is accepted, then `wr_req` rises with `rd_req` low. Expect one cycle with `mem_valid=0`, then a write at `wr_addr` with `mem_we=1`.
- **Write starvation bound:** `rd_req` and `wr_req` both held high, `MAX_RD_RUN=8`. Expect 8 reads, 1 bubble, 1 write, 1 bubble, then reads resume.
- **Clear pass with contention:** `FB_WORDS=16`, `clr_start` pulse with `wr_req` high.
  - 16 clear writes to addresses 0..15 with data 0 precede the plot write.
  - `clr_done` pulses exactly once.
  - A second `clr_start` issued mid-pass has no effect.
- **Backpressure:** `mem_ready=0` for 5 cycles during a write. Expect `mem_addr` and `mem_wdata` stable and `wr_ready` low for those cycles; the transfer completes on the cycle `mem_ready=1`.
- **Reset mid-clear:** assert `reset` at `clr_addr=7`. Expect `clr_busy=0` and `mem_valid=0` the next cycle; a new `clr_start` restarts the pass at address 0.
